// File: rtl/rapid_pkg.sv
// rtl/rapid_pkg.sv - shared types and constants for the rapid_x hazard scoreboard
package rapid_pkg;

  localparam int RAPID_XLEN   = 32;
  localparam int HZ_DEPTH_MAX = 4;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } hazard_entry_t;

endpackage

// File: rtl/rapid_hazard_if.sv
// rtl/rapid_hazard_if.sv - decode/forwarding bundle between pipeline and hazard scoreboard
interface rapid_hazard_if #(
  parameter int XLEN   = 32,
  parameter int NREG_W = 5,
  parameter int DEPTH  = 2
);
  logic                    i_pipeline_ready;
  logic                    i_flush;
  logic                    i_de_valid;
  logic [NREG_W-1:0]       i_de_rs1;
  logic [NREG_W-1:0]       i_de_rs2;
  logic [NREG_W-1:0]       i_de_rd;
  logic                    i_de_rd_we;
  logic                    i_de_is_load;
  logic [XLEN-1:0]         i_rf_rs1_data;
  logic [XLEN-1:0]         i_rf_rs2_data;
  logic [DEPTH*XLEN-1:0]   i_stage_data;
  logic [XLEN-1:0]         o_fwd_rs1;
  logic [XLEN-1:0]         o_fwd_rs2;
  logic                    o_stall;

  modport master (
    output i_pipeline_ready, i_flush, i_de_valid, i_de_rs1, i_de_rs2, i_de_rd,
           i_de_rd_we, i_de_is_load, i_rf_rs1_data, i_rf_rs2_data, i_stage_data,
    input  o_fwd_rs1, o_fwd_rs2, o_stall
  );

  modport slave (
    input  i_pipeline_ready, i_flush, i_de_valid, i_de_rs1, i_de_rs2, i_de_rd,
           i_de_rd_we, i_de_is_load, i_rf_rs1_data, i_rf_rs2_data, i_stage_data,
    output o_fwd_rs1, o_fwd_rs2, o_stall
  );
endinterface

// File: rtl/rapid_fwd_select.sv
// rtl/rapid_fwd_select.sv - per-operand youngest-producer match, readiness check and forward mux
module rapid_fwd_select
  import rapid_pkg::*;
#(
  parameter int XLEN       = RAPID_XLEN,
  parameter int NREG_W     = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 1
) (
  input  hazard_entry_t [DEPTH-1:0] entries,
  input  logic [NREG_W-1:0]         rs,
  input  logic [XLEN-1:0]           rf_data,
  input  logic [DEPTH*XLEN-1:0]     stage_data,
  output logic [XLEN-1:0]           data,
  output logic                      stall_req
);

  logic found;

  // Only the first (youngest) match decides; older producers are never consulted after it.
  always_comb begin
    data      = rf_data;
    stall_req = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && entries[i].valid && (NREG_W'(entries[i].rd) == rs)) begin
        found = 1'b1;
        if (!entries[i].is_load || (i >= LOAD_STAGE)) begin
          data = stage_data[i*XLEN +: XLEN];
        end else begin
          stall_req = 1'b1;
        end
      end
    end
    if (rs == '0) begin
      data      = '0;
      stall_req = 1'b0;
    end
  end

endmodule

// File: rtl/rapid_hazard_scoreboard.sv
// rtl/rapid_hazard_scoreboard.sv - in-flight write scoreboard with forwarding and load-use stall; RAPID_HAZARD_PERF_EN adds stall/flush counters
module rapid_hazard_scoreboard
  import rapid_pkg::*;
#(
  parameter int XLEN       = RAPID_XLEN,
  parameter int NREG_W     = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  rapid_hazard_if.slave hz
`ifdef RAPID_HAZARD_PERF_EN
  ,
  output logic [31:0]   o_stall_cnt,
  output logic [31:0]   o_flush_cnt
`endif
);

  hazard_entry_t [DEPTH-1:0] entries_q;
  hazard_entry_t             insert_entry;
  logic                      stall_rs1;
  logic                      stall_rs2;
  logic                      stall;

  rapid_fwd_select #(
    .XLEN(XLEN), .NREG_W(NREG_W), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)
  ) u_sel_rs1 (
    .entries    (entries_q),
    .rs         (hz.i_de_rs1),
    .rf_data    (hz.i_rf_rs1_data),
    .stage_data (hz.i_stage_data),
    .data       (hz.o_fwd_rs1),
    .stall_req  (stall_rs1)
  );

  rapid_fwd_select #(
    .XLEN(XLEN), .NREG_W(NREG_W), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)
  ) u_sel_rs2 (
    .entries    (entries_q),
    .rs         (hz.i_de_rs2),
    .rf_data    (hz.i_rf_rs2_data),
    .stage_data (hz.i_stage_data),
    .data       (hz.o_fwd_rs2),
    .stall_req  (stall_rs2)
  );

  // A flush kills the decode slot, so it also cancels any stall it would have caused.
  assign stall      = hz.i_de_valid && !hz.i_flush && (stall_rs1 || stall_rs2);
  assign hz.o_stall = stall;

  always_comb begin
    insert_entry = '0;
    if (hz.i_de_valid && !hz.i_flush && !stall) begin
      insert_entry.valid   = hz.i_de_rd_we && (hz.i_de_rd != '0);
      insert_entry.rd      = 5'(hz.i_de_rd);
      insert_entry.is_load = hz.i_de_is_load;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      entries_q <= '0;
    end else if (hz.i_pipeline_ready) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        entries_q[i] <= entries_q[i-1];
      end
      entries_q[0] <= insert_entry;
    end
  end

`ifdef RAPID_HAZARD_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else if (hz.i_pipeline_ready) begin
      if (stall) o_stall_cnt <= o_stall_cnt + 32'd1;
      if (hz.i_flush) o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
